// File: rtl/t05_pkg.sv
// Shared types for the t05 header serializer: command opcodes, FSM states
// and the debug snapshot of the serializer's control state.
package t05_pkg;

  typedef enum logic [1:0] {
    OP_ZERO  = 2'd0,
    OP_CHAR  = 2'd1,
    OP_LEFTS = 2'd2,
    OP_FLUSH = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Debug view of the control state, for checkers bound to the top.
  typedef struct packed {
    state_e state;
    logic   fifo_empty;
    logic   fifo_full;
  } state_cb;

endpackage

// File: rtl/t05_cmd_fifo.sv
// Command FIFO: DEPTH entries, extra pointer bit distinguishes full from empty.
// Writes are refused while full, even if a pop happens in the same cycle.
module t05_cmd_fifo
  import t05_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/t05_header_serializer.sv
// Header serializer: queues ZERO/CHAR/LEFTS/FLUSH commands and shifts each
// record out MSB first, one bit per out_valid/out_ready handshake.
module t05_header_serializer
  import t05_pkg::*;
#(
  parameter  int CHAR_W = 8,
  parameter  int CNT_W  = 8,
  parameter  int DEPTH  = 4,
  localparam int DATA_W = (CHAR_W > CNT_W) ? CHAR_W : CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              busy,
  output logic              write_finish,
  output logic [15:0]       bit_total,
  output state_cb           dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Producers hold valid and payload stable until that edge; ready never
  // depends combinationally on valid.

  localparam int FW    = 2 + DATA_W;
  localparam int SR_W  = DATA_W + 1;
  localparam int LEN_W = $clog2(SR_W + 1);

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        bit_total_q, bit_total_d;

  logic [FW-1:0]      head;
  logic [1:0]         head_op;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic [SR_W-1:0]    char_rec;
  logic [SR_W-1:0]    cnt_rec;

  t05_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .data_i  ({cmd_op, cmd_data}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_op   = head[FW-1 -: 2];
  assign head_data = head[DATA_W-1:0];

  // Records are left-aligned so the first bit to send always sits at the MSB.
  always_comb begin
    char_rec = '0;
    cnt_rec  = '0;
    char_rec[SR_W-1] = 1'b1;
    char_rec[SR_W-2 -: CHAR_W] = head_data[CHAR_W-1:0];
    cnt_rec[SR_W-1] = 1'b1;
    cnt_rec[SR_W-2 -: CNT_W] = head_data[CNT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    len_d       = len_q;
    bit_total_d = bit_total_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (cmd_op_e'(head_op))
            OP_ZERO: begin
              sr_d    = '0;
              len_d   = LEN_W'(1);
              state_d = ST_SHIFT;
            end
            OP_CHAR: begin
              sr_d    = char_rec;
              len_d   = LEN_W'(CHAR_W + 1);
              state_d = ST_SHIFT;
            end
            OP_LEFTS: begin
              // A zero count is a no-op record: consumed, nothing sent.
              if (head_data[CNT_W-1:0] != '0) begin
                sr_d    = cnt_rec;
                len_d   = LEN_W'(CNT_W + 1);
                state_d = ST_SHIFT;
              end
            end
            OP_FLUSH: state_d = ST_FINISH;
          endcase
        end
      end
      ST_SHIFT: begin
        if (out_ready) begin
          sr_d  = sr_q << 1;
          len_d = len_q - 1'b1;
          if (bit_total_q != 16'hFFFF) bit_total_d = bit_total_q + 16'd1;
          if (len_q == LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      len_q       <= '0;
      bit_total_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      len_q       <= len_d;
      bit_total_q <= bit_total_d;
    end
  end

  assign cmd_ready    = !fifo_full;
  assign out_valid    = (state_q == ST_SHIFT);
  assign out_bit      = out_valid & sr_q[SR_W-1];
  assign write_finish = (state_q == ST_FINISH);
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign bit_total    = bit_total_q;

  assign dbg_o.state      = state_q;
  assign dbg_o.fifo_empty = fifo_empty;
  assign dbg_o.fifo_full  = fifo_full;

endmodule

// File: tb/tb_t05_header_serializer.sv
// Bench for t05_header_serializer: directed scenarios plus a randomized run,
// all checked against a bit-stream model built from the command rules.
module tb_t05_header_serializer;
  import t05_pkg::*;

  localparam int CHAR_W = 8;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        busy;
  logic        write_finish;
  logic [15:0] bit_total;
  state_cb     dbg;

  t05_header_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bit      (out_bit),
    .busy         (busy),
    .write_finish (write_finish),
    .bit_total    (bit_total),
    .dbg_o        (dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // exp_q entry: [2] finish marker, [1] last bit of record, [0] bit value
  logic [2:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int exp_total;
  int hs_cnt;
  int fin_cnt;
  int vld_cnt;
  int acc_cnt;
  int rdy_mode;
  bit acc;
  bit prev_stall;
  bit prev_last;
  logic prev_bit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each accepted command appends its full bit record.
  task automatic model_push(input logic [1:0] op, input logic [7:0] d);
    logic [8:0] rec;
    rec = {1'b1, d};
    case (op)
      2'd0: exp_q.push_back(3'b010);
      2'd1: for (int i = CHAR_W; i >= 0; i--) exp_q.push_back({1'b0, i == 0, rec[i]});
      2'd2: if (d != 8'd0)
              for (int i = CHAR_W; i >= 0; i--) exp_q.push_back({1'b0, i == 0, rec[i]});
      default: exp_q.push_back(3'b100);
    endcase
  endtask

  // One clock: observe at negedge, then advance past the rising edge.
  task automatic tick();
    logic [2:0] e;
    bit now_last;
    now_last = 1'b0;
    acc = 1'b0;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_bit", out_bit, prev_bit);
    end
    if (prev_last) chk("record_gap", out_valid, 0);
    if (out_valid) vld_cnt++;
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (exp_total < 65535) exp_total++;
      chk("bit_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bit_value", out_bit, e[0]);
        chk("bit_not_finish", e[2], 0);
        now_last = e[1];
      end
    end
    if (write_finish) begin
      fin_cnt++;
      chk("finish_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("finish_marker", e[2], 1);
      end
    end
    if (cmd_valid && cmd_ready) begin
      acc = 1'b1;
      acc_cnt++;
      model_push(cmd_op, cmd_data);
    end
    prev_stall = out_valid && !out_ready;
    prev_bit   = out_bit;
    prev_last  = now_last;
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: out_ready = !out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] d);
    bit got;
    got = 1'b0;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      got = acc;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", got, 1);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", busy, 0);
    chk("drain_bit_total", bit_total, exp_total);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_write_finish", write_finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_total", bit_total, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_state_idle", dbg.state == ST_IDLE, 1);
    exp_q.delete();
    exp_total  = 0;
    hs_cnt     = 0;
    fin_cnt    = 0;
    vld_cnt    = 0;
    acc_cnt    = 0;
    prev_stall = 1'b0;
    prev_last  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 8'd0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    @(posedge clk);
    #1;

    // CHAR 'A' with out_ready held high, plus first-record latency
    apply_reset();
    push_cmd(2'd1, 8'h41);
    chk("latency_idle_after_accept", out_valid, 0);
    tick();
    chk("latency_valid_next_edge", out_valid, 1);
    drain(100);
    chk("char41_bits", hs_cnt, 9);
    chk("char41_total", bit_total, 9);

    // ZERO, ZERO, LEFTS 3, FLUSH
    apply_reset();
    push_cmd(2'd0, 8'h00);
    push_cmd(2'd0, 8'h00);
    push_cmd(2'd2, 8'd3);
    push_cmd(2'd3, 8'h00);
    drain(100);
    chk("seq_total", bit_total, 11);
    chk("seq_finish_pulses", fin_cnt, 1);

    // LEFTS 0 then FLUSH: no bits at all
    apply_reset();
    push_cmd(2'd2, 8'd0);
    push_cmd(2'd3, 8'h00);
    drain(50);
    chk("lefts0_no_valid", vld_cnt, 0);
    chk("lefts0_finish", fin_cnt, 1);
    chk("lefts0_total", bit_total, 0);

    // CHAR 0xFF with out_ready toggling
    apply_reset();
    rdy_mode = 1;
    push_cmd(2'd1, 8'hFF);
    drain(100);
    rdy_mode  = 0;
    out_ready = 1'b1;
    chk("stall_ff_bits", hs_cnt, 9);

    // Fill the FIFO while the writer is stalled
    apply_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_cmd(2'd1, 8'(i * 17));
    chk("full_cmd_ready_low", cmd_ready, 0);
    cmd_op    = 2'd0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cmd_valid = 1'b0;
    chk("full_no_extra_accept", acc_cnt, 5);
    out_ready = 1'b1;
    drain(200);
    chk("full_total", bit_total, 45);

    // Reset in the middle of a record, then a clean CHAR 0x00
    apply_reset();
    push_cmd(2'd1, 8'hA5);
    for (int i = 0; i < 50 && hs_cnt < 4; i++) tick();
    chk("midrst_bits_before", hs_cnt, 4);
    apply_reset();
    chk("midrst_no_finish", fin_cnt, 0);
    push_cmd(2'd1, 8'h00);
    drain(100);
    chk("midrst_after_total", bit_total, 9);

    // Randomized command mix with random back-pressure
    apply_reset();
    rdy_mode = 2;
    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      logic [7:0] d;
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      if (op == 2'd2 && $urandom_range(0, 3) == 0) d = 8'd0;
      push_cmd(op, d);
      repeat ($urandom_range(0, 3)) tick();
    end
    push_cmd(2'd3, 8'h00);
    drain(5000);
    rdy_mode  = 0;
    out_ready = 1'b1;
    chk("random_total", bit_total, exp_total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t05_header_serializer.md
T05_HEADER_SERIALIZER -- requirements
Module: t05_header_serializer

Interface
REQ-001 SHALL have parameter CHAR_W, default 8: character index width.
REQ-002 SHALL have parameter CNT_W, default 8: left-count width.
REQ-003 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, at least 2.
REQ-004 SHALL derive DATA_W = max(CHAR_W, CNT_W).
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_op  in  2  0=ZERO, 1=CHAR, 2=LEFTS, 3=FLUSH.
REQ-009 cmd_data  in  DATA_W  CHAR: index in [CHAR_W-1:0]; LEFTS: count in [CNT_W-1:0]; otherwise ignored.
REQ-010 cmd_ready  out  1  FIFO can accept a command.
REQ-011 out_valid  out  1  out_bit is valid for the SPI writer.
REQ-012 out_ready  in  1  SPI writer consumes out_bit.
REQ-013 out_bit  out  1  current header bit.
REQ-014 busy  out  1  FIFO non-empty or a shift is in progress.
REQ-015 write_finish  out  1  one-cycle pulse: FLUSH reached, all earlier bits sent.
REQ-016 bit_total  out  16  count of handshaken bits since reset, saturating at 16'hFFFF.

Function
REQ-017 A command SHALL be accepted on a rising edge only when cmd_valid && cmd_ready.
REQ-018 cmd_ready SHALL be !full, with no same-cycle pass-through when full, even if a pop occurs in that cycle.
REQ-019 The FIFO SHALL preserve command order; pointers SHALL wrap modulo DEPTH; full/empty SHALL use an extra pointer bit.
REQ-020 FSM states SHALL be IDLE, SHIFT and FINISH.
REQ-021 IDLE with the FIFO non-empty SHALL pop one command on that edge; IDLE with the FIFO empty SHALL stay in IDLE.
REQ-022 Pop of ZERO SHALL load a single bit 0, length 1, and go to SHIFT.
REQ-023 Pop of CHAR SHALL load {1, index}, length CHAR_W+1, MSB first, and go to SHIFT.
REQ-024 Pop of LEFTS with a non-zero count SHALL load {1, count}, length CNT_W+1, MSB first, and go to SHIFT.
REQ-025 Pop of LEFTS with a zero count SHALL emit nothing and stay in IDLE.
REQ-026 Pop of FLUSH SHALL go to FINISH.
REQ-027 In SHIFT, out_valid SHALL be 1 and out_bit SHALL be the MSB of the shift register.
REQ-028 out_bit SHALL stay stable while out_valid && !out_ready.
REQ-029 On each handshake in SHIFT: shift left by 1, decrement remaining length, increment bit_total.
REQ-030 When the last bit of a record handshakes, the FSM SHALL return to IDLE, with out_valid low for at least one cycle between records.
REQ-031 FINISH SHALL assert write_finish for exactly one cycle, then return to IDLE.
REQ-032 Latency: a command accepted at edge N into an empty idle block SHALL give out_valid=1 after edge N+1.
REQ-033 out_valid SHALL be 0 in IDLE and FINISH.
REQ-034 bit_total SHALL hold at 16'hFFFF once saturated.
REQ-035 A push and a pop in the same cycle (not full) SHALL both take effect, leaving occupancy unchanged.
REQ-036 busy SHALL be 1 whenever the state is not IDLE or the FIFO is non-empty.

Reset
REQ-037 On rst, the FSM SHALL be IDLE, the FIFO empty (pointers 0), and the shift register and length counter 0.
REQ-038 On rst, outputs SHALL be: out_valid=0, out_bit=0, write_finish=0, busy=0, bit_total=0, cmd_ready=1.
REQ-039 rst asserted mid-shift SHALL discard the partial record and all queued commands, with no write_finish pulse.

Structure
REQ-040 The cmd_op encoding enum and the state enum SHALL live in the shared t05 package, alongside state_cb.
REQ-041 The command FIFO SHALL be a sub-module t05_cmd_fifo, parametrised by width (2+DATA_W) and DEPTH.
REQ-042 The serializer FSM, shift register and bit_total SHALL reside in t05_header_serializer.

Verification
REQ-043 Defaults, out_ready=1, CHAR 8'h41 -> bits 1,0,1,0,0,0,0,0,1 on consecutive valid cycles; bit_total=9.
REQ-044 ZERO, ZERO, LEFTS 8'd3, FLUSH -> bits 0 | 0 | 1,0,0,0,0,0,0,1,1; write_finish pulses once after the last bit; bit_total=11.
REQ-045 LEFTS 0 then FLUSH -> no out_valid ever; write_finish pulses; bit_total=0.
REQ-046 out_ready toggled 1/0 during CHAR 8'hFF -> nine 1s; out_bit never changes while stalled.
REQ-047 DEPTH=4, out_ready=0, push 5 commands -> cmd_ready=0 after 4 accepted (or 5 if one popped into SHIFT); none lost; order preserved on release.
REQ-048 rst pulsed after 4 bits of a CHAR -> all outputs at reset values; subsequent CHAR 8'h00 -> 1 followed by eight 0s.
